// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered display word, per-digit
// blanking guard, optional leading-zero suppression, shared external decoder on dec_*.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    lz_en_i,
    output logic [3:0]              dec_digit_o,
    input  logic [6:0]              dec_seg_i,
    output logic [6:0]              seg_n_o,
    output logic [NUM_DIGITS-1:0]   an_n_o,
    output logic                    frame_done_o
);
    localparam int unsigned DispW  = 4 * NUM_DIGITS;
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]       BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic [CntW-1:0]       ShowLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]       IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AnOff     = '1;
    localparam logic [NUM_DIGITS-1:0] AnOne     = NUM_DIGITS'(1);
    localparam logic [6:0]            SegOff    = 7'h7F;

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StShow  = 1'b1;

    logic [DispW-1:0]      disp_q, disp_d;
    logic [DispW-1:0]      pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [0:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_end;
    logic                  xfer;
    logic                  suppress;

    assign dec_digit_o = disp_q[4*idx_q +: 4];

    // Digit is a leading zero when it and every more-significant nibble are zero.
    assign suppress  = lz_en_i && (idx_q != '0) && ((disp_q >> (4 * idx_q)) == '0);
    assign frame_end = (state_q == StShow) && (cnt_q == ShowLast) && (idx_q == IdxLast);
    assign xfer      = !enable_i || frame_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (!enable_i) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == StBlank) begin
            if (cnt_q == BlankLast) begin
                state_d = StShow;
                cnt_d   = '0;
            end
        end else if (cnt_q == ShowLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
    end

    // A load coinciding with a transfer lands in pend after the old pend moves to disp.
    always_comb begin
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (xfer && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        if (load_i) begin
            pend_d     = value_i;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        seg_n_d      = SegOff;
        an_n_d       = AnOff;
        frame_done_d = 1'b0;
        if (enable_i && (state_q == StShow)) begin
            if (!suppress) begin
                seg_n_d = dec_seg_i;
                an_n_d  = ~(AnOne << idx_q);
            end
            frame_done_d = frame_end;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_n_q      <= SegOff;
            an_n_q       <= AnOff;
            frame_done_q <= 1'b0;
        end else begin
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n_o      = seg_n_q;
    assign an_n_o       = an_n_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: slot-position reference model feeding an expectation queue,
// monitor compares pins every cycle.
module tb_seven_seg_scan_ctrl;
    localparam int ND    = 4;
    localparam int RDIV  = 4;
    localparam int BCYC  = 2;
    localparam int SLOT  = RDIV + BCYC;
    localparam int FRAME = ND * SLOT;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       fd;
        logic [3:0] dd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  dec_digit;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t expq[$];

    // Model state: ph counts cycles since the scan (re)started at digit 0 blanking.
    int          m_ph;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pvld;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign dec_seg = hex7(dec_digit);

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RDIV),
        .BLANK_CYC  (BCYC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .load_i      (load),
        .value_i     (value),
        .lz_en_i     (lz_en),
        .dec_digit_o (dec_digit),
        .dec_seg_i   (dec_seg),
        .seg_n_o     (seg_n),
        .an_n_o      (an_n),
        .frame_done_o(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ph   = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pvld = 1'b0;
    endtask

    task automatic push_blank();
        exp_t e;
        e.seg = 7'h7F;
        e.an  = 4'hF;
        e.fd  = 1'b0;
        e.dd  = 4'h0;
        expq.push_back(e);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        push_blank();
        m_reset();
    endtask

    // Drive one cycle of inputs and queue the pin values expected after the next edge.
    task automatic cycle(input logic en, input logic ld, input logic [15:0] val, input logic lz);
        exp_t e;
        int   pos;
        int   slot;
        int   nslot;
        logic xfer;
        logic lit;
        @(negedge clk);
        rst    = 1'b0;
        enable = en;
        load   = ld;
        value  = val;
        lz_en  = lz;
        e.seg  = 7'h7F;
        e.an   = 4'hF;
        e.fd   = 1'b0;
        if (en) begin
            pos  = m_ph % FRAME;
            slot = pos / SLOT;
            lit  = (pos % SLOT) >= BCYC;
            if (lz && slot > 0 && (m_disp >> (4 * slot)) == 16'h0) lit = 1'b0;
            if (lit) begin
                e.seg = hex7(m_disp[4*slot +: 4]);
                e.an  = ~(4'b0001 << slot);
            end
            e.fd = (pos == FRAME - 1);
            xfer = (pos == FRAME - 1);
            m_ph++;
        end else begin
            xfer = 1'b1;
            m_ph = 0;
        end
        if (xfer && m_pvld) begin
            m_disp = m_pend;
            m_pvld = 1'b0;
        end
        if (ld) begin
            m_pend = val;
            m_pvld = 1'b1;
        end
        nslot = (m_ph % FRAME) / SLOT;
        e.dd  = m_disp[4*nslot +: 4];
        expq.push_back(e);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_seg", int'(seg_n), 'h7F);
        check("async_an", int'(an_n), 'hF);
        push_blank();
        m_reset();
        rst_cycle();
        rst_cycle();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("seg_n", int'(seg_n), int'(e.seg));
                check("an_n", int'(an_n), int'(e.an));
                check("frame_done", int'(frame_done), int'(e.fd));
                check("dec_digit", int'(dec_digit), int'(e.dd));
            end
        end
    end

    initial begin
        logic [15:0] v;
        logic        lz;
        rst    = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'h0;
        lz_en  = 1'b0;
        m_reset();
        repeat (2) rst_cycle();

        // Load while idle so the word reaches disp before scanning starts.
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (48) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // Mid-frame load at digit 2 must wait for the frame boundary.
        while (m_ph % FRAME != 14) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'hABCD, 1'b0);
        repeat (40) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // Leading-zero suppression.
        cycle(1'b1, 1'b1, 16'h0050, 1'b1);
        repeat (48) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 16'h0000, 1'b1);
        repeat (48) cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Drop enable during digit 2 SHOW, then resume.
        cycle(1'b1, 1'b1, 16'h1234, 1'b0);
        repeat (24) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        while (m_ph % FRAME != 16) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (30) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // Asynchronous reset while digit 2 is lit.
        while (m_ph % FRAME != 15) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        async_reset();
        repeat (30) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // Random traffic; nibbles zeroed often so suppression gets exercised.
        lz = 1'b0;
        repeat (400) begin
            v = 16'($urandom);
            for (int i = 0; i < ND; i++) begin
                if ($urandom_range(1, 0) == 0) v[4*i +: 4] = 4'h0;
            end
            if ($urandom_range(49, 0) == 0) lz = ~lz;
            cycle(($urandom_range(15, 0) != 0), ($urandom_range(19, 0) == 0), v, lz);
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
